// File: rtl/knn_pkg.sv
// Shared definitions for the kNN sort controller: default sizes, derived widths
// and the sequencer state encoding.
package knn_pkg;

    localparam int W_DEF    = 32;
    localparam int HW_K_DEF = 10;
    localparam int NW_DEF   = 16;
    localparam int IDXW     = W_DEF / 4;
    localparam int DISTW    = W_DEF + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_WAIT_D = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_SETTLE = 3'd4,
        ST_FREEZE = 3'd5,
        ST_READ   = 3'd6,
        ST_FIN    = 3'd7
    } knn_state_e;

    function automatic int idx_width(input int w);
        return w / 4;
    endfunction

    function automatic int dist_width(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/knn_out_reg.sv
// Single-entry valid/ready output register for the ranked index stream.
module knn_out_reg
    import knn_pkg::*;
#(
    parameter int IW = IDXW,
    parameter int NW = NW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_idx,
    input  logic [NW-1:0] in_rank,
    input  logic          in_last,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [IW-1:0] o_idx,
    output logic [NW-1:0] o_rank,
    output logic          o_last
);

    logic          valid_q, valid_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [NW-1:0] rank_q, rank_d;
    logic          last_q, last_d;

    assign in_ready = !valid_q || o_ready;

    // Load a new beat when the slot frees up; otherwise hold or drain.
    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        rank_d  = rank_q;
        last_d  = last_q;
        if (in_valid && in_ready) begin
            valid_d = 1'b1;
            idx_d   = in_idx;
            rank_d  = in_rank;
            last_d  = in_last;
        end else if (o_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            rank_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            rank_q  <= rank_d;
            last_q  <= last_d;
        end
    end

    assign o_valid = valid_q;
    assign o_idx   = idx_q;
    assign o_rank  = rank_q;
    assign o_last  = last_q;

endmodule

// File: rtl/knn_sort_ctrl.sv
// Sequencer for the K-nearest insertion sorter: clears it, feeds distances with
// the two-cycle insert timing, freezes it and streams the K best indices out.
module knn_sort_ctrl
    import knn_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int HW_K = HW_K_DEF,
    parameter int NW   = NW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [NW-1:0]  n_points,
    output logic           busy,
    output logic           done,
    input  logic           d_valid,
    output logic           d_ready,
    input  logic [W:0]     d_dist,
    output logic           srt_rst,
    output logic           srt_valid,
    output logic           srt_done,
    output logic [W:0]     srt_dist,
    output logic [15:0]    srt_sel,
    input  logic [W/4-1:0] srt_idx,
    output logic           o_valid,
    input  logic           o_ready,
    output logic [W/4-1:0] o_idx,
    output logic [NW-1:0]  o_rank,
    output logic           o_last
);

    localparam int IW = idx_width(W);
    localparam int DW = dist_width(W);
    localparam logic [NW:0]   N_CAP = (NW+1)'(64'd1 << IW);
    localparam logic [NW-1:0] K_CNT = NW'(HW_K);

    knn_state_e    state_q, state_d;
    logic [NW-1:0] n_eff_q, n_eff_d;
    logic [NW-1:0] acc_q, acc_d;
    logic [NW-1:0] r_q, r_d;
    logic [NW-1:0] cnt_out_q, cnt_out_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          d_ready_q, d_ready_d;
    logic          srt_rst_q, srt_rst_d;
    logic          srt_valid_q, srt_valid_d;
    logic          srt_done_q, srt_done_d;
    logic [DW-1:0] srt_dist_q, srt_dist_d;
    logic [15:0]   srt_sel_q, srt_sel_d;

    logic [NW-1:0] n_cap;
    logic          d_accept;
    logic          out_in_valid;
    logic          out_in_ready;
    logic          out_valid;
    logic          out_last;
    logic          beat_load;

    // More points than the index field can name would alias indices.
    assign n_cap        = ({1'b0, n_points} > N_CAP) ? N_CAP[NW-1:0] : n_points;
    assign d_accept     = (state_q == ST_WAIT_D) && d_valid && d_ready_q;
    assign out_in_valid = (state_q == ST_READ) && (r_q < cnt_out_q);
    assign beat_load    = out_in_valid && out_in_ready;

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d    = state_q;
        n_eff_d    = n_eff_q;
        acc_d      = acc_q;
        r_d        = r_q;
        cnt_out_d  = cnt_out_q;
        srt_dist_d = srt_dist_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_eff_d = n_cap;
                    acc_d   = '0;
                    state_d = (n_cap == '0) ? ST_FIN : ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR:  state_d = ST_WAIT_D;
            ST_WAIT_D: begin
                if (d_accept) begin
                    srt_dist_d = d_dist;
                    acc_d      = acc_q + NW'(1);
                    state_d    = ST_ISSUE;
                end else begin
                    state_d = ST_WAIT_D;
                end
            end
            ST_ISSUE:  state_d = ST_SETTLE;
            ST_SETTLE: state_d = (acc_q == n_eff_q) ? ST_FREEZE : ST_WAIT_D;
            ST_FREEZE: begin
                r_d       = '0;
                cnt_out_d = (n_eff_q < K_CNT) ? n_eff_q : K_CNT;
                state_d   = ST_READ;
            end
            ST_READ: begin
                if (beat_load) begin
                    r_d = r_q + NW'(1);
                end else begin
                    r_d = r_q;
                end
                if (out_valid && o_ready && out_last) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with it.
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_FIN);
        done_d      = (state_d == ST_FIN);
        d_ready_d   = (state_d == ST_WAIT_D);
        srt_rst_d   = (state_d == ST_CLEAR);
        srt_valid_d = (state_d == ST_ISSUE);
        srt_done_d  = !(state_d inside {ST_CLEAR, ST_WAIT_D, ST_ISSUE, ST_SETTLE});
        srt_sel_d   = (state_d == ST_READ) ? 16'(r_d) : 16'd0;
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            n_eff_q     <= '0;
            acc_q       <= '0;
            r_q         <= '0;
            cnt_out_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            d_ready_q   <= 1'b0;
            srt_rst_q   <= 1'b0;
            srt_valid_q <= 1'b0;
            srt_done_q  <= 1'b1;
            srt_dist_q  <= '0;
            srt_sel_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            n_eff_q     <= n_eff_d;
            acc_q       <= acc_d;
            r_q         <= r_d;
            cnt_out_q   <= cnt_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            d_ready_q   <= d_ready_d;
            srt_rst_q   <= srt_rst_d;
            srt_valid_q <= srt_valid_d;
            srt_done_q  <= srt_done_d;
            srt_dist_q  <= srt_dist_d;
            srt_sel_q   <= srt_sel_d;
        end
    end

    knn_out_reg #(
        .IW (IW),
        .NW (NW)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .in_valid (out_in_valid),
        .in_ready (out_in_ready),
        .in_idx   (srt_idx),
        .in_rank  (r_q),
        .in_last  (r_q == (cnt_out_q - NW'(1))),
        .o_valid  (out_valid),
        .o_ready  (o_ready),
        .o_idx    (o_idx),
        .o_rank   (o_rank),
        .o_last   (out_last)
    );

    // The sorter must see its clear for as long as the system reset is held.
    assign srt_rst   = srt_rst_q | rst;
    assign busy      = busy_q;
    assign done      = done_q;
    assign d_ready   = d_ready_q;
    assign srt_valid = srt_valid_q;
    assign srt_done  = srt_done_q;
    assign srt_dist  = srt_dist_q;
    assign srt_sel   = srt_sel_q;
    assign o_valid   = out_valid;
    assign o_last    = out_last;

endmodule

// File: tb/tb_knn_sort_ctrl.sv
// Self-checking bench for knn_sort_ctrl with a behavioural insertion sorter
// and a scoreboard of expected readout beats.
module tb_knn_sort_ctrl;

    localparam int W    = 32;
    localparam int HW_K = 10;
    localparam int NW   = 16;
    localparam int IW   = W / 4;
    localparam logic signed [W:0] MAXD = {1'b0, {W{1'b1}}};

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NW-1:0] n_points;
    logic          busy, done;
    logic          d_valid, d_ready;
    logic [W:0]    d_dist;
    logic          srt_rst, srt_valid, srt_done;
    logic [W:0]    srt_dist;
    logic [15:0]   srt_sel;
    logic [IW-1:0] srt_idx;
    logic          o_valid, o_ready;
    logic [IW-1:0] o_idx;
    logic [NW-1:0] o_rank;
    logic          o_last;
    logic          bp_mode;

    always #5 clk = ~clk;

    knn_sort_ctrl #(.W(W), .HW_K(HW_K), .NW(NW)) dut (
        .clk(clk), .rst(rst), .start(start), .n_points(n_points),
        .busy(busy), .done(done), .d_valid(d_valid), .d_ready(d_ready),
        .d_dist(d_dist), .srt_rst(srt_rst), .srt_valid(srt_valid),
        .srt_done(srt_done), .srt_dist(srt_dist), .srt_sel(srt_sel),
        .srt_idx(srt_idx), .o_valid(o_valid), .o_ready(o_ready),
        .o_idx(o_idx), .o_rank(o_rank), .o_last(o_last)
    );

    // Behavioural sorter: strict less-than insertion, cleared by srt_rst.
    logic signed [W:0] sd [16];
    logic [IW-1:0]     si [16];
    logic [IW-1:0]     scnt;

    assign srt_idx = (srt_sel < 16'(HW_K)) ? si[srt_sel[3:0]] : '0;

    function automatic int ins_pos(input logic signed [W:0] d);
        int p = HW_K;
        for (int i = HW_K - 1; i >= 0; i--) begin
            if (d < sd[i]) p = i;
        end
        return p;
    endfunction

    always @(posedge clk) begin
        if (srt_rst) begin
            for (int i = 0; i < 16; i++) begin
                sd[i] <= MAXD;
                si[i] <= '0;
            end
            scnt <= '0;
        end else if (srt_valid && !srt_done) begin
            for (int i = 0; i < HW_K; i++) begin
                if (i == ins_pos($signed(srt_dist))) begin
                    sd[i] <= $signed(srt_dist);
                    si[i] <= scnt;
                end else if (i > ins_pos($signed(srt_dist))) begin
                    sd[i] <= sd[i-1];
                    si[i] <= si[i-1];
                end
            end
            scnt <= scnt + 1'b1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    typedef struct { int idx; int rank; int last; } beat_t;
    beat_t exp_q[$];
    int    stim[$];

    // Monitor state (written only by the monitor process).
    int         done_cnt = 0, sv_cnt = 0, srst_cnt = 0;
    bit         stall_p = 1'b0, sv_p = 1'b0;
    logic [W:0] sv_dist;
    int         p_idx, p_rank, p_last;

    always @(negedge clk) begin
        if (rst) begin
            stall_p <= 1'b0;
            sv_p    <= 1'b0;
        end else begin
            if (done)      done_cnt <= done_cnt + 1;
            if (srt_valid) sv_cnt   <= sv_cnt + 1;
            if (srt_rst)   srst_cnt <= srst_cnt + 1;
            if (sv_p) begin
                check_eq("valid_gap", srt_valid, 0);
                check_eq("dist_hold", srt_dist, sv_dist);
            end
            sv_p    <= srt_valid;
            sv_dist <= srt_dist;
            if (stall_p) begin
                check_eq("hold_valid", o_valid, 1);
                check_eq("hold_idx", o_idx, p_idx);
                check_eq("hold_rank", o_rank, p_rank);
                check_eq("hold_last", o_last, p_last);
            end
            stall_p <= o_valid && !o_ready;
            p_idx   <= int'(o_idx);
            p_rank  <= int'(o_rank);
            p_last  <= int'(o_last);
            if (o_valid && o_ready) begin
                check_eq("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check_eq("beat_idx", o_idx, exp_q[0].idx);
                    check_eq("beat_rank", o_rank, exp_q[0].rank);
                    check_eq("beat_last", o_last, exp_q[0].last);
                    exp_q.delete(0);
                end
            end
        end
    end

    initial begin
        o_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            o_ready = bp_mode ? !o_ready : 1'b1;
        end
    end

    task automatic feed_one(input int v);
        bit ok = 1'b0;
        d_valid = 1'b1;
        d_dist  = (W+1)'(v);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (d_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        check_eq("accept_timeout", ok, 1);
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk);
        #1;
        start    = 1'b1;
        n_points = NW'(n);
        @(posedge clk);
        #1;
        start    = 1'b0;
        n_points = 16'hFFFF;
    endtask

    task automatic run_case(input int n, input bit bp, input int glitch_at);
        int    n_eff, cnt, best, lat, b_done, b_sv, b_srst;
        bit    seen;
        bit    used [0:511];
        beat_t b;
        n_eff = (n > 256) ? 256 : n;
        cnt   = (n_eff < HW_K) ? n_eff : HW_K;
        for (int i = 0; i < 512; i++) used[i] = 1'b0;
        for (int r = 0; r < cnt; r++) begin
            best = -1;
            for (int i = 0; i < n_eff; i++) begin
                if (!used[i] && (best < 0 || stim[i] < stim[best])) best = i;
            end
            used[best] = 1'b1;
            b.idx  = best;
            b.rank = r;
            b.last = (r == cnt - 1) ? 1 : 0;
            exp_q.push_back(b);
        end
        b_done  = done_cnt;
        b_sv    = sv_cnt;
        b_srst  = srst_cnt;
        bp_mode = bp;
        pulse_start(n);
        for (int j = 0; j < n; j++) begin
            if (j == glitch_at) pulse_start(2);
            feed_one(stim[j]);
        end
        seen = 1'b0;
        lat  = 0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("done_seen", seen, 1);
        if (n == 0) check_eq("done_latency_le2", lat <= 2, 1);
        repeat (4) @(negedge clk);
        check_eq("done_once", done_cnt - b_done, 1);
        check_eq("beats_left", exp_q.size(), 0);
        check_eq("busy_after", busy, 0);
        check_eq("valid_pulses", sv_cnt - b_sv, n_eff);
        check_eq("clear_pulses", srst_cnt - b_srst, (n > 0) ? 1 : 0);
        bp_mode = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int b_done;
        rst = 1'b1; start = 1'b0; n_points = '0;
        d_valid = 1'b0; d_dist = '0; bp_mode = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_d_ready", d_ready, 0);
        check_eq("rst_srt_rst", srt_rst, 1);
        check_eq("rst_srt_valid", srt_valid, 0);
        check_eq("rst_srt_done", srt_done, 1);
        check_eq("rst_srt_dist", srt_dist, 0);
        check_eq("rst_srt_sel", srt_sel, 0);
        check_eq("rst_o_valid", o_valid, 0);
        check_eq("rst_o_idx", o_idx, 0);
        check_eq("rst_o_rank", o_rank, 0);
        check_eq("rst_o_last", o_last, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("idle_srt_rst", srt_rst, 0);

        stim = '{40, 10, 30, 20, 50};
        run_case(5, 1'b0, -1);

        stim.delete();
        for (int i = 0; i < 12; i++) stim.push_back(12 - i);
        run_case(12, 1'b0, -1);

        stim = '{40, 10, 30, 20, 50};
        run_case(5, 1'b1, -1);

        stim.delete();
        run_case(0, 1'b0, -1);

        // Abandon a run with a reset while waiting for the third distance.
        b_done = done_cnt;
        pulse_start(5);
        feed_one(9);
        feed_one(8);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (d_ready) break;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("abort_no_done", done_cnt - b_done, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_o_valid", o_valid, 0);

        stim = '{7, 7, 1};
        run_case(3, 1'b0, -1);

        stim = '{40, 10, 30, 20, 50};
        run_case(5, 1'b0, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/knn_sort_ctrl.md
Name: knn_sort_ctrl

Overview:
- Sequencer for the K-nearest insertion sorter in the kNN accelerator.
- Clears the sorter and accepts a stream of N signed distances from the distance unit.
- Feeds each distance into the sorter with the two-cycle valid/insert timing the sorter requires, then freezes it (DONE).
- Reads the K best indices out through a valid/ready stream, nearest first.

Parameters:
W, 32, distance width; distances are W+1 bits signed, indices are W/4 bits.
HW_K, 10, number of sorter slots (K).
NW, 16, width of the point-count and rank fields.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a run when idle
n_points  in  NW  number of distances in this run; sampled on start
busy  out  1  high from accepted start until the last readout beat
done  out  1  one-cycle pulse after the last readout beat (or immediately for n_points=0)
d_valid  in  1  distance available
d_ready  out  1  controller accepts distance
d_dist  in  W+1  signed distance
srt_rst  out  1  sorter clear (drives sorter rst)
srt_valid  out  1  sorter insert request (drives sorter valid)
srt_done  out  1  sorter freeze (drives sorter DONE)
srt_dist  out  W+1  held distance (drives sorter DIST)
srt_sel  out  16  slot select (drives sorter SEL)
srt_idx  in  W/4  sorter DATA_OUT (combinational from srt_sel)
o_valid  out  1  result beat valid
o_ready  in  1  consumer accepts beat
o_idx  out  W/4  point index of rank o_rank
o_rank  out  NW  0 = nearest
o_last  out  1  final beat of the run

Behaviour:
- Reset values:
  - busy=0, done=0, d_ready=0.
  - srt_rst=1 while rst is high, else as per state.
  - srt_valid=0, srt_done=1, srt_dist=0, srt_sel=0.
  - o_valid=0, o_idx=0, o_rank=0, o_last=0.
  - FSM returns to IDLE.
- A reset mid-run abandons the run: no done pulse, no further beats.
- States are IDLE, CLEAR, WAIT_D, ISSUE, SETTLE, FREEZE, READ, FIN.
- IDLE:
  - srt_done=1.
  - On start, latch n_eff = min(n_points, 2^(W/4)) and zero the accepted counter.
  - If n_eff=0, go to FIN; otherwise go to CLEAR.
  - start while busy is ignored.
- CLEAR: one cycle with srt_rst=1 and srt_done=0. This clears the sorter slots to max distance and its index counter. Go to WAIT_D.
- WAIT_D:
  - d_ready=1.
  - On d_valid&d_ready, register d_dist into srt_dist, assert srt_valid next cycle, increment the accepted counter, and go to ISSUE.
- ISSUE: srt_valid=1 and srt_dist is held. Go to SETTLE.
- SETTLE:
  - srt_valid=0 and srt_dist is still held, because the sorter compares during the cycle after valid.
  - If accepted==n_eff, go to FREEZE; otherwise go to WAIT_D.
  - Throughput is at most one distance per 3 cycles.
- FREEZE: srt_done=1 from here on, srt_sel=0, rank counter r=0, cnt_out = min(n_eff, HW_K). Go to READ.
- READ: drive srt_sel=r; the sorter output is combinational.
  - When the output register is empty, or full with o_ready=1, load o_idx=srt_idx, o_rank=r, o_last=(r==cnt_out-1) and o_valid=1, then increment r.
  - o_idx, o_rank and o_last hold stable while o_valid&!o_ready.
  - After the beat with o_last is accepted, go to FIN.
  - Readout never exceeds cnt_out, so n_eff<K never exposes empty slots.
- FIN: done=1 for one cycle, busy=0. Go to IDLE.
- busy=1 in every state except IDLE and FIN.
- srt_done=0 only from CLEAR through SETTLE.
- d_ready is 0 outside WAIT_D; d_valid outside WAIT_D is held off, not dropped.
- Ties: equal distances keep the earlier index ahead; the sorter uses a strict less-than compare, and the controller preserves arrival order.

Decomposition:
- Package knn_pkg holds:
  - FSM state encoding (3-bit localparams).
  - HW_K and W defaults.
  - Derived widths IDXW=W/4 and DISTW=W+1.
- One sub-module, knn_out_reg: the single-entry valid/ready output register holding o_idx, o_rank and o_last.
- The top instantiates the FSM and counters only; the sorter is instantiated beside it by the integrating top.

Test Plan:
1. Reset, then n_points=5 with distances 40,10,30,20,50 (HW_K=10), o_ready=1.
   - Required: beats idx 1,3,2,0,4 with ranks 0..4, o_last on rank 4, then one done pulse.
   - Required: srt_valid high exactly 5 cycles, each followed by a held-srt_dist cycle.
2. n_points=12 with distances 12 down to 1.
   - Required: 10 beats, idx 11,10,…,2, o_last on rank 9.
3. Backpressure: scenario 1 with o_ready toggling 0/1 every cycle.
   - Required: the same 5 beats, each held stable while o_ready=0, none lost or duplicated.
4. n_points=0.
   - Required: done pulses 2 cycles after start, no o_valid, srt_rst never asserted.
5. Assert rst during WAIT_D after 2 distances, then start a new run with n_points=3 and distances 7,7,1.
   - Required: first run emits nothing; second run emits idx 2,0,1 (tie keeps order).
6. Pulse start while busy mid-run.
   - Required: ignored; n_points latched from the first start is unchanged and the run completes normally.
